// File: rtl/console_ctrl.sv
// console_ctrl: text-console sequencer for an 80x30 frame buffer.
// Each cell holds one word, {attr[23:0], char[7:0]}.
//
// The controller takes a byte stream from the CPU and owns the frame buffer
// write port. It tracks the cursor, decodes control codes, and runs the
// scroll, blank and clear sweeps. While it scrolls it also takes the read port.
//
// Ports:
//   iClk, iRst        clock; synchronous active-high reset
//   iValid/iChar/iAttr  byte stream in, with attribute sampled alongside iChar
//   oReady            the controller accepts a byte this cycle
//   oWriteEn/oWAddr/oWData  registered frame buffer write port
//   oRAddr/iRData     frame buffer read port (read data is combinational)
//   oRdOwn            the controller owns the read port (SCROLL only)
//   oCurCol/oCurRow   cursor position
//   oBusy             high in any state other than IDLE
module console_ctrl #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter logic [23:0] BLANK_ATTR = 24'hFFFFFF
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  input  logic [7:0]  iChar,
  input  logic [23:0] iAttr,
  output logic        oReady,
  output logic        oWriteEn,
  output logic [31:0] oWAddr,
  output logic [31:0] oWData,
  output logic [31:0] oRAddr,
  input  logic [31:0] iRData,
  output logic        oRdOwn,
  output logic [6:0]  oCurCol,
  output logic [4:0]  oCurRow,
  output logic        oBusy
);
  localparam int          NCELL       = COLS * ROWS;
  localparam int          KW          = $clog2(NCELL);
  localparam logic [31:0] BLANK_WORD  = {BLANK_ATTR, 8'h20};
  localparam logic [KW-1:0] SCROLL_LAST = KW'((ROWS - 1) * COLS - 1);
  localparam logic [KW-1:0] CELL_LAST   = KW'(NCELL - 1);

  typedef enum logic [1:0] {IDLE, SCROLL, BLANK, CLEAR} state_t;

  state_t        state, state_d;
  logic [KW-1:0] k, k_d;
  logic [6:0]    col, col_d;
  logic [4:0]    row, row_d;
  logic          wen, wen_d;
  logic [31:0]   waddr, waddr_d, wdata, wdata_d;
  logic [31:0]   cur_addr;
  logic          printable, nl;

  assign cur_addr  = 32'(row) * 32'(COLS) + 32'(col);
  assign printable = (iChar >= 8'h20) && (iChar != 8'h7F);

  assign oReady   = (state == IDLE) && !iRst;
  assign oBusy    = (state != IDLE);
  assign oRdOwn   = (state == SCROLL);
  // Source row for the destination cell k is one screen row below it.
  assign oRAddr   = 32'(k) + 32'(COLS);
  assign oWriteEn = wen;
  assign oWAddr   = waddr;
  assign oWData   = wdata;
  assign oCurCol  = col;
  assign oCurRow  = row;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
      k     <= '0;
      col   <= '0;
      row   <= '0;
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      state <= state_d;
      k     <= k_d;
      col   <= col_d;
      row   <= row_d;
      wen   <= wen_d;
      waddr <= waddr_d;
      wdata <= wdata_d;
    end
  end

  always_comb begin
    state_d = state;
    k_d     = k;
    col_d   = col;
    row_d   = row;
    wen_d   = 1'b0;
    waddr_d = waddr;
    wdata_d = wdata;
    nl      = 1'b0;

    case (state)
      IDLE: begin
        if (iValid && oReady) begin
          if (printable) begin
            wen_d   = 1'b1;
            waddr_d = cur_addr;
            wdata_d = {iAttr, iChar};
            if (col == 7'(COLS - 1)) nl = 1'b1;
            else                     col_d = col + 7'd1;
          end else begin
            case (iChar)
              8'h0A: nl = 1'b1;
              8'h0D: col_d = '0;
              8'h08: begin
                // Backspace never wraps to the previous row.
                if (col != '0) begin
                  col_d   = col - 7'd1;
                  wen_d   = 1'b1;
                  waddr_d = cur_addr - 32'd1;
                  wdata_d = BLANK_WORD;
                end
              end
              8'h0C: begin
                state_d = CLEAR;
                k_d     = '0;
                col_d   = '0;
                row_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      SCROLL: begin
        wen_d   = 1'b1;
        waddr_d = 32'(k);
        wdata_d = iRData;
        k_d     = k + 1'b1;
        // k carries straight on into the last row, which BLANK fills.
        if (k == SCROLL_LAST) state_d = BLANK;
      end
      BLANK, CLEAR: begin
        wen_d   = 1'b1;
        waddr_d = 32'(k);
        wdata_d = BLANK_WORD;
        if (k == CELL_LAST) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Newline from LF or from wrapping past the last column. On the bottom
    // row the cursor stays put and the screen scrolls instead.
    if (nl) begin
      col_d = '0;
      if (row == 5'(ROWS - 1)) begin
        state_d = SCROLL;
        k_d     = '0;
      end else begin
        row_d = row + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_console_ctrl.sv
module tb_console_ctrl;
  localparam int          NCELL = 2400;
  localparam logic [31:0] BLANK = 32'hFFFFFF20;

  logic        iClk = 1'b0;
  logic        iRst, iValid;
  logic [7:0]  iChar;
  logic [23:0] iAttr;
  logic        oReady, oWriteEn, oRdOwn, oBusy;
  logic [31:0] oWAddr, oWData, oRAddr, iRData;
  logic [6:0]  oCurCol;
  logic [4:0]  oCurRow;

  logic [31:0] mem [0:NCELL-1];
  int tests = 0, fails = 0;

  console_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iChar(iChar), .iAttr(iAttr),
    .oReady(oReady), .oWriteEn(oWriteEn), .oWAddr(oWAddr), .oWData(oWData),
    .oRAddr(oRAddr), .iRData(iRData), .oRdOwn(oRdOwn),
    .oCurCol(oCurCol), .oCurRow(oCurRow), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  // Behavioural frame buffer: combinational read, clocked write.
  assign iRData = (oRAddr < NCELL) ? mem[oRAddr[11:0]] : 32'h0;
  always @(posedge iClk)
    if (oWriteEn && oWAddr < NCELL) mem[oWAddr[11:0]] <= oWData;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a byte, wait (bounded) for oReady, handshake on the next edge.
  // Returns at edge+1 so the registered write for this byte is visible.
  task automatic send(input logic [7:0] c, input logic [23:0] a);
    int n = 0;
    @(negedge iClk);
    while (!oReady && n < 5000) begin @(negedge iClk); n++; end
    if (n >= 5000) begin
      tests++; fails++;
      $display("FAIL send_timeout: got busy expected ready");
    end
    iValid = 1'b1; iChar = c; iAttr = a;
    @(posedge iClk); #1;
    iValid = 1'b0;
  endtask

  task automatic chk_cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, 32'(oCurCol), 32'(c));
    chk({tag, "_row"}, 32'(oCurRow), 32'(r));
  endtask

  initial begin
    int n, bad, bad_busy;
    for (int i = 0; i < NCELL; i++) mem[i] = 32'h0;
    iRst = 1'b1; iValid = 1'b0; iChar = 8'h0; iAttr = 24'h0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_wen", 32'(oWriteEn), 0);
    chk("rst_waddr", oWAddr, 0);
    chk("rst_wdata", oWData, 0);
    chk("rst_rdown", 32'(oRdOwn), 0);
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_ready", 32'(oReady), 0);
    chk_cur("rst", 0, 0);
    @(negedge iClk); iRst = 1'b0;

    // 'H','i'
    send("H", 24'hFFFFFF);
    chk("H_wen", 32'(oWriteEn), 1); chk("H_addr", oWAddr, 0); chk("H_data", oWData, 32'hFFFFFF48);
    send("i", 24'hFFFFFF);
    chk("i_wen", 32'(oWriteEn), 1); chk("i_addr", oWAddr, 1); chk("i_data", oWData, 32'hFFFFFF69);
    @(posedge iClk); #1;
    chk("i_one_cycle", 32'(oWriteEn), 0);
    chk_cur("hi", 2, 0);

    // 0x7F is consumed silently
    send(8'h7F, 24'h0);
    chk("del_nowrite", 32'(oWriteEn), 0);
    chk_cur("del", 2, 0);

    // Back to column 0, then a full row of 'A'
    send(8'h0D, 24'h0);
    chk_cur("cr0", 0, 0);
    for (int i = 0; i < 80; i++) send("A", 24'h00FF00);
    chk("A_last_addr", oWAddr, 79);
    chk("A_last_data", oWData, 32'h00FF0041);
    chk_cur("A80", 0, 1);
    send(8'h0D, 24'h0);
    chk("cr_nowrite", 32'(oWriteEn), 0);
    chk_cur("cr", 0, 1);

    // Cursor to (5,3), then backspace
    send(8'h0A, 24'h0); send(8'h0A, 24'h0);
    send("a", 24'h123456); send("b", 24'h123456); send("c", 24'h123456);
    send("d", 24'h123456); send("e", 24'h123456);
    chk_cur("pre_bs", 5, 3);
    send(8'h08, 24'h0);
    chk("bs_wen", 32'(oWriteEn), 1); chk("bs_addr", oWAddr, 244); chk("bs_data", oWData, BLANK);
    chk_cur("bs", 4, 3);
    send(8'h0D, 24'h0);
    send(8'h08, 24'h0);
    chk("bs0_nowrite", 32'(oWriteEn), 0);
    chk_cur("bs0", 0, 3);

    // Scroll: preload @80, cursor to (0,29), LF
    mem[80] = 32'h00FF0041;
    for (int i = 0; i < 26; i++) send(8'h0A, 24'h0);
    chk_cur("pre_scroll", 0, 29);
    send(8'h0A, 24'h0);
    chk("scroll_rdown", 32'(oRdOwn), 1);
    n = 0;
    while (!oReady && n < 3000) begin @(posedge iClk); #1; n++; end
    chk("scroll_cycles", n, 2400);
    chk("scroll_last_addr", oWAddr, 2399);
    chk("scroll_rdown_off", 32'(oRdOwn), 0);
    @(posedge iClk); #1;
    chk("scroll_mem0", mem[0], 32'h00FF0041);
    chk("scroll_mem163", mem[163], 32'h12345664);
    chk("scroll_mem164", mem[164], BLANK);
    bad = 0;
    for (int a = 2320; a < 2400; a++) if (mem[a] !== BLANK) bad++;
    chk("scroll_blank_row", bad, 0);
    chk_cur("scroll", 0, 29);

    // Form feed clears the screen in ascending order
    send(8'h0C, 24'h0);
    bad = 0; bad_busy = 0;
    for (int i = 0; i < NCELL; i++) begin
      if (oBusy !== 1'b1) bad_busy++;
      @(posedge iClk); #1;
      if (!(oWriteEn === 1'b1 && oWAddr === 32'(i) && oWData === BLANK)) bad++;
    end
    chk("ff_busy", bad_busy, 0);
    chk("ff_writes", bad, 0);
    chk("ff_ready", 32'(oReady), 1);
    chk_cur("ff", 0, 0);

    // Reset during a scroll
    for (int i = 0; i < 29; i++) send(8'h0A, 24'h0);
    send(8'h0A, 24'h0);
    repeat (99) @(posedge iClk);
    #1;
    chk("mid_rdown", 32'(oRdOwn), 1);
    iRst = 1'b1;
    @(posedge iClk); #1;
    chk("abort_wen", 32'(oWriteEn), 0);
    chk("abort_rdown", 32'(oRdOwn), 0);
    chk("abort_ready_in_rst", 32'(oReady), 0);
    chk_cur("abort", 0, 0);
    iRst = 1'b0; #1;
    chk("abort_ready", 32'(oReady), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/console_ctrl.md
Name: console_ctrl

Overview:
- Text-console controller that sequences the display frame buffer: 80x30 words, one word per cell as {attr[23:0], char[7:0]}.
- Accepts a byte stream from the CPU over a valid/ready handshake and owns the frame buffer write port.
- Tracks the cursor, handles control characters, and performs hardware scroll and clear.
- Borrows the frame buffer read port during scroll; the display scanner owns that port at all other times via an external mux driven by oRdOwn.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows on screen
- BLANK_ATTR, 24'hFFFFFF, attribute written with space (0x20) when blanking cells

Ports:
- iClk  input  1  system clock
- iRst  input  1  synchronous reset, active-high
- iValid  input  1  byte available
- iChar  input  8  byte to print or control code
- iAttr  input  24  attribute for printable byte, sampled with iChar
- oReady  output  1  controller accepts a byte this cycle
- oWriteEn  output  1  frame buffer write enable
- oWAddr  output  32  frame buffer write address
- oWData  output  32  frame buffer write data
- oRAddr  output  32  frame buffer read address (meaningful only while oRdOwn=1)
- iRData  input  32  frame buffer read data (combinational from oRAddr)
- oRdOwn  output  1  controller owns the read port
- oCurCol  output  7  cursor column
- oCurRow  output  5  cursor row
- oBusy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock iClk. Reset iRst is synchronous and active-high.
- Reset values: state IDLE, cursor (0,0), oWriteEn=0, oWAddr=0, oWData=0, oRdOwn=0, oBusy=0, oReady=0 while iRst=1.
- Handshake and interface timing:
  - oReady = (state==IDLE) && !iRst.
  - A byte is accepted when iValid && oReady.
  - All write-port outputs are registered: the write for an accepted byte appears the cycle after the handshake and lasts exactly 1 cycle.
- Cursor address: cursor cell address = row*COLS + col.
- Byte decode in IDLE:
  - 0x20..0x7E and 0x80..0xFF: write {iAttr, iChar} at the cursor, then advance col. If col==COLS-1: col=0, row+1.
  - 0x0A (LF): col=0, row+1.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): if col>0, col-1 and write {BLANK_ATTR, 0x20} at the new position. At col 0, no effect (no row wrap).
  - 0x0C (FF): enter CLEAR. Cursor set to (0,0).
  - Any other code below 0x20, and 0x7F: consumed, no effect.
- Row overflow: when a row increment would make row==ROWS, row stays ROWS-1 and the FSM enters SCROLL after the printable write, if any, is issued.
- SCROLL:
  - Index k runs 0..(ROWS-1)*COLS-1, one step per cycle.
  - oRdOwn=1, oRAddr=k+COLS (combinational from k).
  - Next cycle: oWriteEn=1, oWAddr=k, oWData=iRData as sampled.
  - After the last k, go to BLANK.
- BLANK:
  - k runs (ROWS-1)*COLS..ROWS*COLS-1, writing {BLANK_ATTR, 0x20}.
  - oRdOwn=0. Then return to IDLE.
- CLEAR: k runs 0..ROWS*COLS-1, writing blank words. Then IDLE.
- Timing: SCROLL+BLANK take ROWS*COLS cycles (2400 default). CLEAR takes 2400 cycles. The final write lands the cycle after leaving the state; oReady reasserts in that same cycle.
- Reset mid-operation: immediate abort. Buffer contents are left partially updated, cursor goes to (0,0), and the next cycle shows no write.
- iValid while busy: ignored. The byte must be held by the source until oReady=1.

Test Plan:
- Reset, then send 'H','i' with iAttr=FFFFFF: writes 0xFFFFFF48 @0 and 0xFFFFFF69 @1, each one cycle after its handshake; cursor ends at (2,0).
- Send 80 'A' bytes: last write @79; cursor ends at (0,1). Then send CR: cursor stays (0,1) and no write occurs.
- Cursor at (5,3), send BS: write 0xFFFFFF20 @244; cursor ends at (4,3). Cursor at (0,3), send BS: no write, cursor unchanged.
- Preload word @80 = 0x00FF0041, cursor at (0,29), send LF:
  - oReady is low for 2400 cycles.
  - Write @0 = 0x00FF0041.
  - Addresses 2320..2399 are written with 0xFFFFFF20.
  - Cursor ends at (0,29).
- Send FF: 2400 blank writes @0..2399 in ascending order; cursor ends at (0,0); oBusy is high throughout.
- Assert iRst at cycle 100 of a scroll: next cycle oWriteEn=0, oRdOwn=0, cursor (0,0), oReady=1 after iRst drops.
